// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants one of init/refresh/write/read at a time
// and multiplexes the owner's command, bank and address onto the device pins.
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        init_end,
    input  logic        aref_req,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    input  logic        aref_end,
    input  logic        wr_req,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_addr,
    input  logic        wr_end,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_data,
    input  logic        rd_req,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_addr,
    input  logic        rd_end,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cmd_s;

    // Next-state: fixed priority aref > wr > rd; ends only honoured by their owner
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_INIT: begin
                if (init_end) state_nxt_s = S_ARBIT;
                else          state_nxt_s = S_INIT;
            end
            S_ARBIT: begin
                if (aref_req)    state_nxt_s = S_AREF;
                else if (wr_req) state_nxt_s = S_WRITE;
                else if (rd_req) state_nxt_s = S_READ;
                else             state_nxt_s = S_ARBIT;
            end
            S_AREF: begin
                if (aref_end) state_nxt_s = S_ARBIT;
                else          state_nxt_s = S_AREF;
            end
            S_WRITE: begin
                if (wr_end) state_nxt_s = S_ARBIT;
                else        state_nxt_s = S_WRITE;
            end
            S_READ: begin
                if (rd_end) state_nxt_s = S_ARBIT;
                else        state_nxt_s = S_READ;
            end
            default: state_nxt_s = S_INIT;
        endcase
    end

    // State, grants and clock enable; grants track the state being entered
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= S_INIT;
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            sdram_cke <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            aref_en   <= (state_nxt_s == S_AREF);
            wr_en     <= (state_nxt_s == S_WRITE);
            rd_en     <= (state_nxt_s == S_READ);
            sdram_cke <= 1'b1;
        end
    end

    // Pin mux driven purely from the state register so reset takes effect at once
    always_comb begin
        cmd_s       = CMD_NOP;
        sdram_ba    = 2'b00;
        sdram_addr  = 13'd0;
        sdram_dq_oe = 1'b0;
        case (state_r)
            S_INIT: begin
                cmd_s      = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                cmd_s      = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            S_WRITE: begin
                cmd_s       = wr_cmd;
                sdram_ba    = wr_ba;
                sdram_addr  = wr_addr;
                sdram_dq_oe = wr_sdram_en;
            end
            S_READ: begin
                cmd_s      = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd_s       = CMD_NOP;
                sdram_ba    = 2'b00;
                sdram_addr  = 13'd0;
                sdram_dq_oe = 1'b0;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_s;
    assign sdram_dq_out = wr_data;

endmodule
